pixel_fetch: RTL and testbench

- Display-side consumer of the sync generator's timing: PCK, HS, VS, ENABLE_MEM, HCNT, VCNT.
- Converts each active pixel position into a frame-buffer read address and issues a one-cycle read.
- Maps the returned Julia iteration count through a fixed palette to 12-bit RGB, with HS/VS delayed to match.
- Owns double-buffer selection: swaps the displayed buffer at frame boundary on request from the fractal compute engine.

---
 rtl/pixel_fetch.sv | 155 +++++++++++++++
 tb/tb_pixel_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch.sv
// Display-side pixel fetch: turns sync-generator timing into frame-buffer reads,
// maps iteration counts through the palette to RGB and owns double-buffer selection.
module pixel_fetch #(
  parameter int HSIZE    = 640,
  parameter int VSIZE    = 480,
  parameter int HFRONT   = 160,
  parameter int VFRONT   = 45,
  parameter int ADDR_W   = 20,
  parameter int RD_LAT   = 2,
  parameter int MAX_ITER = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PCK,
  input  logic              HS_IN,
  input  logic              VS_IN,
  input  logic              BLANK_IN,
  input  logic [9:0]        HCNT,
  input  logic [9:0]        VCNT,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [7:0]        RD_DATA,
  input  logic              FRAME_DONE,
  output logic              BUF_SEL,
  output logic              FRAME_START,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS
);

  localparam logic [9:0]        HFRONT_C = 10'(HFRONT);
  localparam logic [9:0]        VFRONT_C = 10'(VFRONT);
  localparam logic [9:0]        HSIZE_C  = 10'(HSIZE);
  localparam logic [9:0]        VSIZE_C  = 10'(VSIZE);
  localparam logic [ADDR_W-1:0] HSIZE_A  = ADDR_W'(HSIZE);
  localparam logic [ADDR_W-1:0] BUF_OFS  = ADDR_W'(HSIZE * VSIZE);
  localparam logic [7:0]        MAX_C    = 8'(MAX_ITER);

  // Pipeline stage bit layout
  localparam int P_UPD = 3;
  localparam int P_VIS = 2;
  localparam int P_HS  = 1;
  localparam int P_VS  = 0;

  logic              pck_q1_reg;
  logic              pck_q2_reg;
  logic              pck_rise;
  logic              vs_prev_reg;
  logic              vs_rise;
  logic              pending_reg;
  logic [9:0]        hoff;
  logic [9:0]        voff;
  logic              vis;
  logic [ADDR_W-1:0] addr_next;
  logic [3:0]        pipe_reg [RD_LAT+1];
  logic [3:0]        pipe_out;

  assign pck_rise = pck_q1_reg & ~pck_q2_reg;

  // Offsets wrap for positions left of / above the visible window, so a single
  // unsigned compare rejects both sides.
  assign hoff = HCNT - HFRONT_C;
  assign voff = VCNT - VFRONT_C;
  assign vis  = ~BLANK_IN & (hoff < HSIZE_C) & (voff < VSIZE_C);

  assign addr_next = (BUF_SEL ? BUF_OFS : '0)
                   + (ADDR_W'(voff) * HSIZE_A)
                   + ADDR_W'(hoff);

  assign vs_rise  = pck_rise & VS_IN & ~vs_prev_reg;
  assign pipe_out = pipe_reg[RD_LAT];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pck_q1_reg <= 1'b0;
      pck_q2_reg <= 1'b0;
    end else begin
      pck_q1_reg <= PCK;
      pck_q2_reg <= pck_q1_reg;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RD_EN   <= 1'b0;
      RD_ADDR <= '0;
    end else begin
      RD_EN <= pck_rise & vis;
      if (pck_rise && vis) begin
        RD_ADDR <= addr_next;
      end
    end
  end

  // Pixel metadata travels alongside the read so it lines up with RD_DATA.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe_reg[i] <= '0;
      end
    end else begin
      pipe_reg[0] <= {pck_rise, vis, HS_IN, VS_IN};
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      VGA_R  <= 4'h0;
      VGA_G  <= 4'h0;
      VGA_B  <= 4'h0;
      VGA_HS <= 1'b0;
      VGA_VS <= 1'b0;
    end else if (pipe_out[P_UPD]) begin
      if (pipe_out[P_VIS] && (RD_DATA != MAX_C)) begin
        VGA_R <= RD_DATA[7:4];
        VGA_G <= RD_DATA[3:0];
        VGA_B <= ~RD_DATA[3:0];
      end else begin
        VGA_R <= 4'h0;
        VGA_G <= 4'h0;
        VGA_B <= 4'h0;
      end
      VGA_HS <= pipe_out[P_HS];
      VGA_VS <= pipe_out[P_VS];
    end
  end

  // A FRAME_DONE coinciding with the swap is consumed by it rather than re-arming.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vs_prev_reg <= 1'b0;
      pending_reg <= 1'b0;
      BUF_SEL     <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= 1'b0;
      if (pck_rise) begin
        vs_prev_reg <= VS_IN;
      end
      if (vs_rise && (pending_reg || FRAME_DONE)) begin
        BUF_SEL     <= ~BUF_SEL;
        pending_reg <= 1'b0;
        FRAME_START <= 1'b1;
      end else if (FRAME_DONE) begin
        pending_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch: a latency-accurate frame-buffer model
// plus queues of expected reads and expected colour/sync outputs.
module tb_pixel_fetch;

  localparam int HSIZE  = 640;
  localparam int VSIZE  = 480;
  localparam int HFRONT = 160;
  localparam int VFRONT = 45;
  localparam int ADDR_W = 20;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_pix_t;

  logic              CLK;
  logic              RST;
  logic              PCK;
  logic              HS_IN;
  logic              VS_IN;
  logic              BLANK_IN;
  logic [9:0]        HCNT;
  logic [9:0]        VCNT;
  logic              RD_EN;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [7:0]        RD_DATA;
  logic              FRAME_DONE;
  logic              BUF_SEL;
  logic              FRAME_START;
  logic [3:0]        VGA_R;
  logic [3:0]        VGA_G;
  logic [3:0]        VGA_B;
  logic              VGA_HS;
  logic              VGA_VS;

  int       n_checks = 0;
  int       n_fail   = 0;
  int       fs_cnt   = 0;
  int       exp_buf  = 0;
  logic     rd_en_prev = 1'b0;
  logic     fs_prev    = 1'b0;
  logic [7:0] pix_data = 8'hFF;
  logic [1:0] en_sh    = 2'b00;
  int       rd_q[$];
  exp_pix_t out_q[$];

  pixel_fetch dut (
    .CLK(CLK), .RST(RST), .PCK(PCK), .HS_IN(HS_IN), .VS_IN(VS_IN),
    .BLANK_IN(BLANK_IN), .HCNT(HCNT), .VCNT(VCNT), .RD_EN(RD_EN),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .FRAME_DONE(FRAME_DONE),
    .BUF_SEL(BUF_SEL), .FRAME_START(FRAME_START), .VGA_R(VGA_R),
    .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Frame buffer with 2-cycle latency; off-cycle data is MAX_ITER (black).
  always @(posedge CLK) en_sh <= {en_sh[0], RD_EN};
  assign RD_DATA = en_sh[1] ? pix_data : 8'hFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Read and FRAME_START monitor
  always @(negedge CLK) begin
    if (RD_EN) begin
      check("rd_pulse_width", 32'(rd_en_prev), 0);
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", 32'(RD_ADDR), 32'(rd_q.pop_front()));
    end
    if (FRAME_START) begin
      check("fs_pulse_width", 32'(fs_prev), 0);
      fs_cnt++;
    end
    rd_en_prev = RD_EN;
    fs_prev    = FRAME_START;
  end

  function automatic logic [11:0] colour(input logic v, input logic [7:0] d);
    if (!v || d == 8'hFF) return 12'h000;
    return {d[7:4], d[3:0], ~d[3:0]};
  endfunction

  task automatic pixel(input int h, input int v, input logic blank, input logic hs,
                       input logic vs, input logic [7:0] d, input logic fd);
    int       ho, vo;
    logic     visible;
    exp_pix_t e, got;
    @(negedge CLK);
    HCNT = 10'(h); VCNT = 10'(v); BLANK_IN = blank; HS_IN = hs; VS_IN = vs;
    pix_data = d;
    ho = h - HFRONT;
    vo = v - VFRONT;
    visible = !blank && ho >= 0 && ho < HSIZE && vo >= 0 && vo < VSIZE;
    if (visible) rd_q.push_back((exp_buf * HSIZE * VSIZE + vo * HSIZE + ho) % (1 << ADDR_W));
    e.rgb = colour(visible, d); e.hs = hs; e.vs = vs;
    out_q.push_back(e);
    PCK = 1'b1;
    @(negedge CLK);
    FRAME_DONE = fd;
    @(negedge CLK);
    FRAME_DONE = 1'b0;
    repeat (3) @(negedge CLK);
    got.rgb = {VGA_R, VGA_G, VGA_B}; got.hs = VGA_HS; got.vs = VGA_VS;
    e = out_q.pop_front();
    check("rgb", 32'(got.rgb), 32'(e.rgb));
    check("sync", {30'd0, got.hs, got.vs}, {30'd0, e.hs, e.vs});
    $display("pixel h=%0d v=%0d blank=%0b data=%02h rgb=%03h hs=%0b vs=%0b buf=%0b",
             h, v, blank, d, got.rgb, got.hs, got.vs, BUF_SEL);
    repeat (3) @(negedge CLK);
    PCK = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic frame_done_pulse;
    @(negedge CLK);
    FRAME_DONE = 1'b1;
    @(negedge CLK);
    FRAME_DONE = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {RD_EN, 12'(RD_ADDR), BUF_SEL, FRAME_START, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0;
    RST = 1'b0; PCK = 1'b0; HS_IN = 1'b0; VS_IN = 1'b0; BLANK_IN = 1'b1;
    HCNT = '0; VCNT = '0; FRAME_DONE = 1'b0;
    repeat (4) @(negedge CLK);
    check_idle_outputs("reset_state");
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // First visible pixels: consecutive addresses from buffer 0
    pixel(HFRONT,     VFRONT, 0, 0, 0, 8'h5A, 0);
    pixel(HFRONT + 1, VFRONT, 0, 0, 0, 8'h12, 0);
    check("buf_sel_init", 32'(BUF_SEL), 0);
    pixel(HFRONT + 2, VFRONT, 0, 0, 0, 8'hFF, 0);
    pixel(HFRONT + 3, VFRONT, 0, 1, 0, 8'hC3, 0);

    // Swap on VS rise after a mid-frame FRAME_DONE
    fs0 = fs_cnt;
    frame_done_pulse();
    pixel(10, 10, 1, 0, 0, 8'h00, 0);
    pixel(11, 10, 1, 0, 1, 8'h00, 0);
    exp_buf = 1;
    check("swap_buf", 32'(BUF_SEL), 1);
    check("swap_fs", 32'(fs_cnt - fs0), 1);
    fs0 = fs_cnt;
    pixel(12, 10, 1, 0, 0, 8'h00, 0);
    pixel(13, 10, 1, 0, 1, 8'h00, 0);
    check("noswap_buf", 32'(BUF_SEL), 1);
    check("noswap_fs", 32'(fs_cnt - fs0), 0);

    // Boundary positions in buffer 1
    pixel(HFRONT + HSIZE - 1, VFRONT + VSIZE - 1, 0, 0, 0, 8'h37, 0);
    pixel(HFRONT + HSIZE,     VFRONT + VSIZE - 1, 0, 0, 0, 8'h37, 0);
    pixel(HFRONT + 5,         VFRONT + VSIZE,     0, 0, 0, 8'h37, 0);
    pixel(HFRONT - 1,         VFRONT,             0, 0, 0, 8'h37, 0);
    pixel(HFRONT + 10,        VFRONT - 1,         0, 0, 0, 8'h37, 0);
    pixel(200, 100, 1, 0, 0, 8'h5A, 0);

    for (int i = 0; i < 4; i++) begin
      pixel(HFRONT + $urandom_range(0, HSIZE - 1), VFRONT + $urandom_range(0, VSIZE - 1),
            0, 1'($urandom_range(0, 1)), 0, 8'($urandom_range(0, 254)), 0);
    end

    // FRAME_DONE coincident with the sampled VS rise
    fs0 = fs_cnt;
    pixel(20, 5, 1, 0, 0, 8'h00, 0);
    pixel(21, 5, 1, 0, 1, 8'h00, 1);
    exp_buf = 0;
    check("same_cycle_buf", 32'(BUF_SEL), 0);
    pixel(22, 5, 1, 0, 0, 8'h00, 0);
    pixel(23, 5, 1, 0, 1, 8'h00, 0);
    check("same_cycle_fs", 32'(fs_cnt - fs0), 1);
    check("same_cycle_buf2", 32'(BUF_SEL), 0);

    // Several FRAME_DONE pulses in one frame give one swap
    fs0 = fs_cnt;
    frame_done_pulse();
    frame_done_pulse();
    frame_done_pulse();
    pixel(24, 5, 1, 0, 0, 8'h00, 0);
    pixel(25, 5, 1, 0, 1, 8'h00, 0);
    exp_buf = 1;
    pixel(26, 5, 1, 0, 0, 8'h00, 0);
    pixel(27, 5, 1, 0, 1, 8'h00, 0);
    check("multi_fd_fs", 32'(fs_cnt - fs0), 1);
    check("multi_fd_buf", 32'(BUF_SEL), 1);

    // Reset mid-line while RD_EN is high
    @(negedge CLK);
    HCNT = 10'(HFRONT + 10); VCNT = 10'(VFRONT + 5); BLANK_IN = 1'b0;
    HS_IN = 1'b1; VS_IN = 1'b0; pix_data = 8'h44;
    rd_q.push_back(exp_buf * HSIZE * VSIZE + 5 * HSIZE + 10);
    PCK = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rd_en_before_reset", 32'(RD_EN), 1);
    #2;
    RST = 1'b0;
    PCK = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    exp_buf = 0;
    pixel(HFRONT + 10, VFRONT + 5, 0, 0, 0, 8'h9C, 0);
    check("post_reset_buf", 32'(BUF_SEL), 0);

    repeat (10) @(negedge CLK);
    check("rd_missing", 32'(rd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
